tlb_ctrl: RTL and testbench
===========================

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; IW = $clog2(TLBNUM) SHALL be the index width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 reserved.
REQ-007 cmd_inv_op  in  5  INV opcode.
REQ-008 cmd_asid  in  10  CSR.ASID (SRCH) or rj ASID (INV).
REQ-009 cmd_vppn  in  19  CSR.TLBEHI VPPN (SRCH) or rk VA[31:13] (INV).
REQ-010 csr_idx  in  IW+7  {ne, ps[5:0], index} from CSR.TLBIDX.
REQ-011 csr_tlbr  in  1  high when ESTAT.Ecode==0x3F.
REQ-012 csr_elo0  in  27  {ppn[19:0], plv[1:0], mat[1:0], d, v, g}.
REQ-013 csr_elo1  in  27  same layout as csr_elo0.
REQ-014 s_vppn  out  19  TLB search VPPN.
REQ-015 s_asid  out  10  TLB search ASID.
REQ-016 s_found  in  1  TLB search hit.
REQ-017 s_index  in  IW  TLB search hit index.
REQ-018 invtlb_valid  out  1  TLB invalidate strobe.
REQ-019 invtlb_op  out  5  TLB invalidate opcode.
REQ-020 we  out  1  TLB write strobe.
REQ-021 w_index  out  IW  TLB write index.
REQ-022 w_entry  out  89  {e, vppn[18:0], ps[5:0], asid[9:0], g, lo0[25:0], lo1[25:0]}, where lo = {ppn, plv, mat, d, v}.
REQ-023 r_index  out  IW  TLB read index.
REQ-024 r_entry  in  89  TLB read data, w_entry layout, combinational from r_index.
REQ-025 rsp_valid  out  1  one-cycle completion pulse.
REQ-026 rsp_found  out  1  SRCH hit.
REQ-027 rsp_index  out  IW  SRCH hit index, or FILL index used.
REQ-028 rsp_entry  out  89  RD result.
REQ-029 rsp_err  out  1  reserved cmd_op, or INV opcode > 6.

Function
REQ-030 FSM states IDLE->EXEC->RESP->IDLE, unconditional after acceptance; cmd_ready SHALL equal (state==IDLE).
REQ-031 On acceptance, all cmd_* and csr_* inputs SHALL be latched; later input changes SHALL have no effect on that command.
REQ-032 In EXEC, s_vppn/s_asid SHALL carry the latched cmd_vppn/cmd_asid; r_index SHALL carry latched csr_idx.index; rsp_* SHALL be captured at the end of EXEC.
REQ-033 we and invtlb_valid SHALL be high only in EXEC, for exactly one cycle per command.
REQ-034 SRCH: rsp_found=s_found; rsp_index=s_index on hit, else 0.
REQ-035 RD: if r_entry.e=1, rsp_entry=r_entry; else rsp_entry=0 with e=0.
REQ-036 WR: we=1, w_index=csr_idx.index.
REQ-037 FILL: we=1, w_index=fill_ptr.
REQ-038 WR and FILL: w_entry.e = csr_tlbr | ~csr_idx.ne; vppn/asid from latched cmd; ps from csr_idx.ps unmodified; g = elo0.g & elo1.g.
REQ-039 fill_ptr SHALL reset to 0 and increment by 1 after each FILL, wrapping from TLBNUM-1 to 0.
REQ-040 INV: invtlb_op=cmd_inv_op; invtlb_valid SHALL be suppressed, and rsp_err=1, when the opcode exceeds 6.
REQ-041 Reserved cmd_op: no TLB strobe; rsp_err=1.
REQ-042 rsp_valid SHALL be high in RESP only; rsp_* SHALL hold their values until the next RESP.
REQ-043 Throughput SHALL be one command per 3 cycles; acceptance at cycle T SHALL give rsp_valid at T+2 and cmd_ready at T+3.

Reset
REQ-044 resetn low SHALL immediately force IDLE, cmd_ready=1, we=0, invtlb_valid=0, rsp_valid=0, and all rsp_*=0, fill_ptr=0; no pending command survives.
REQ-045 Reset asserted during EXEC SHALL cancel that cycle's strobe combinationally.

Verification
REQ-046 SRCH vppn=0x12345, asid=5, TLB hit at index 7 -> rsp_valid at T+2, rsp_found=1, rsp_index=7, we=0.
REQ-047 Four FILLs with ne=1, csr_tlbr=1 -> w_index 0,1,2,3, each w_entry.e=1; seventeen FILLs with TLBNUM=16 -> 17th w_index=0.
REQ-048 WR index=3, ne=1, csr_tlbr=0, elo0.g=1, elo1.g=0 -> single we pulse, w_index=3, e=0, g=0.
REQ-049 INV op=5, then op=9 -> first: one invtlb_valid pulse with invtlb_op=5; second: no pulse, rsp_err=1.
REQ-050 RD of an entry with e=0 -> rsp_entry=0; cmd_valid held high throughout -> cmd_ready low for exactly 2 cycles per command; resetn pulse during EXEC of a WR -> no we pulse, IDLE next.

Source files
------------

// File: rtl/tlb_ctrl.sv
// TLB instruction controller: sequences SRCH/RD/WR/FILL/INV commands against the
// TLB search, read, write and invalidate ports, one command every three cycles.
module tlb_ctrl #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [4:0]    cmd_inv_op,
  input  logic [9:0]    cmd_asid,
  input  logic [18:0]   cmd_vppn,
  input  logic [IW+6:0] csr_idx,
  input  logic          csr_tlbr,
  input  logic [26:0]   csr_elo0,
  input  logic [26:0]   csr_elo1,
  output logic [18:0]   s_vppn,
  output logic [9:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic          invtlb_valid,
  output logic [4:0]    invtlb_op,
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [88:0]   w_entry,
  output logic [IW-1:0] r_index,
  input  logic [88:0]   r_entry,
  output logic          rsp_valid,
  output logic          rsp_found,
  output logic [IW-1:0] rsp_index,
  output logic [88:0]   rsp_entry,
  output logic          rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t        state_r, state_nx_s;
  logic          accept_s;
  logic [2:0]    op_r;
  logic [4:0]    inv_op_r;
  logic [9:0]    asid_r;
  logic [18:0]   vppn_r;
  logic [IW+6:0] idx_r;
  logic          tlbr_r;
  logic [26:0]   elo0_r, elo1_r;
  logic [IW-1:0] fill_ptr_r;
  logic          exec_s;
  logic          rsp_found_nx_s;
  logic [IW-1:0] rsp_index_nx_s;
  logic [88:0]   rsp_entry_nx_s;
  logic          rsp_err_nx_s;

  assign accept_s = cmd_valid & (state_r == ST_IDLE);
  assign exec_s   = (state_r == ST_EXEC);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic: every accepted command walks EXEC then RESP
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_nx_s = ST_EXEC;
        else           state_nx_s = ST_IDLE;
      end
      ST_EXEC: state_nx_s = ST_RESP;
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs; strobes derive from the state register so reset kills them at once
  always_comb begin
    cmd_ready    = (state_r == ST_IDLE);
    rsp_valid    = (state_r == ST_RESP);
    we           = exec_s & ((op_r == OP_WR) | (op_r == OP_FILL));
    invtlb_valid = exec_s & (op_r == OP_INV) & (inv_op_r <= 5'd6);
  end

  // Command capture at acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_r     <= 3'd0;
      inv_op_r <= 5'd0;
      asid_r   <= 10'd0;
      vppn_r   <= 19'd0;
      idx_r    <= '0;
      tlbr_r   <= 1'b0;
      elo0_r   <= 27'd0;
      elo1_r   <= 27'd0;
    end else if (accept_s) begin
      op_r     <= cmd_op;
      inv_op_r <= cmd_inv_op;
      asid_r   <= cmd_asid;
      vppn_r   <= cmd_vppn;
      idx_r    <= csr_idx;
      tlbr_r   <= csr_tlbr;
      elo0_r   <= csr_elo0;
      elo1_r   <= csr_elo1;
    end
  end

  assign s_vppn    = vppn_r;
  assign s_asid    = asid_r;
  assign r_index   = idx_r[IW-1:0];
  assign invtlb_op = inv_op_r;
  assign w_index   = (op_r == OP_FILL) ? fill_ptr_r : idx_r[IW-1:0];
  // A refill exception forces the entry valid regardless of TLBIDX.NE
  assign w_entry   = {tlbr_r | ~idx_r[IW+6], vppn_r, idx_r[IW+5:IW], asid_r,
                      elo0_r[0] & elo1_r[0], elo0_r[26:1], elo1_r[26:1]};

  // Response values computed during EXEC
  always_comb begin
    rsp_found_nx_s = 1'b0;
    rsp_index_nx_s = '0;
    rsp_entry_nx_s = 89'd0;
    rsp_err_nx_s   = 1'b0;
    case (op_r)
      OP_SRCH: begin
        rsp_found_nx_s = s_found;
        if (s_found) rsp_index_nx_s = s_index;
        else         rsp_index_nx_s = '0;
      end
      OP_RD: begin
        if (r_entry[88]) rsp_entry_nx_s = r_entry;
        else             rsp_entry_nx_s = 89'd0;
      end
      OP_WR:   rsp_err_nx_s   = 1'b0;
      OP_FILL: rsp_index_nx_s = fill_ptr_r;
      OP_INV:  rsp_err_nx_s   = (inv_op_r > 5'd6);
      default: rsp_err_nx_s   = 1'b1;
    endcase
  end

  // Response registers, held until the next command's EXEC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_found <= 1'b0;
      rsp_index <= '0;
      rsp_entry <= 89'd0;
      rsp_err   <= 1'b0;
    end else if (exec_s) begin
      rsp_found <= rsp_found_nx_s;
      rsp_index <= rsp_index_nx_s;
      rsp_entry <= rsp_entry_nx_s;
      rsp_err   <= rsp_err_nx_s;
    end
  end

  // Round-robin FILL pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_ptr_r <= '0;
    end else if (exec_s && (op_r == OP_FILL)) begin
      if (fill_ptr_r == IW'(TLBNUM - 1)) fill_ptr_r <= '0;
      else                               fill_ptr_r <= fill_ptr_r + IW'(1);
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Scoreboard bench for tlb_ctrl: directed commands push expected strobes and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_tlb_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW = 4;

  localparam logic [25:0] LO0 = 26'h2AF3C5B;
  localparam logic [25:0] LO1 = 26'h1234567;
  localparam logic [88:0] ENT9 = {1'b1, 88'h5A5A_1234_5678_9ABC_DEF0_11};
  localparam logic [88:0] ENT2 = {1'b0, 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF};

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [4:0]    cmd_inv_op = 5'd0;
  logic [9:0]    cmd_asid = 10'd0;
  logic [18:0]   cmd_vppn = 19'd0;
  logic [IW+6:0] csr_idx = '0;
  logic          csr_tlbr = 1'b0;
  logic [26:0]   csr_elo0 = 27'd0, csr_elo1 = 27'd0;
  logic [18:0]   s_vppn;
  logic [9:0]    s_asid;
  logic          s_found;
  logic [IW-1:0] s_index;
  logic          invtlb_valid, we, rsp_valid, rsp_found, rsp_err;
  logic [4:0]    invtlb_op;
  logic [IW-1:0] w_index, r_index, rsp_index;
  logic [88:0]   w_entry, r_entry, rsp_entry;

  always #5 clk = ~clk;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_inv_op(cmd_inv_op), .cmd_asid(cmd_asid), .cmd_vppn(cmd_vppn),
    .csr_idx(csr_idx), .csr_tlbr(csr_tlbr), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .we(we), .w_index(w_index),
    .w_entry(w_entry), .r_index(r_index), .r_entry(r_entry), .rsp_valid(rsp_valid),
    .rsp_found(rsp_found), .rsp_index(rsp_index), .rsp_entry(rsp_entry), .rsp_err(rsp_err)
  );

  // Minimal TLB: one mapping for search, a fixed table for reads
  always_comb begin
    s_found = (s_vppn == 19'h12345) && (s_asid == 10'd5);
    s_index = s_found ? 4'd7 : 4'd11;
    if (r_index == 4'd9)      r_entry = ENT9;
    else if (r_index == 4'd2) r_entry = ENT2;
    else                      r_entry = 89'd0;
  end

  typedef struct {
    logic        found;
    logic [3:0]  index;
    logic [88:0] entry;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        is_inv;
    logic [3:0]  index;
    logic [88:0] entry;
    logic [4:0]  op;
    int          cyc;
  } stb_t;

  rsp_t rq[$];
  stb_t sq[$];
  rsp_t mr;
  stb_t ms;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [88:0] ent(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                      input logic [9:0] asid, input logic g,
                                      input logic [25:0] lo0, input logic [25:0] lo1);
    return {e, vppn, ps, asid, g, lo0, lo1};
  endfunction

  // Monitor: pops scoreboard entries whenever the DUT presents a strobe or response
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=none");
      end else begin
        mr = rq.pop_front();
        chk("rsp_found", 89'(rsp_found), 89'(mr.found));
        chk("rsp_index", 89'(rsp_index), 89'(mr.index));
        chk("rsp_entry", rsp_entry, mr.entry);
        chk("rsp_err", 89'(rsp_err), 89'(mr.err));
        chk("rsp_cycle", 89'(cyc), 89'(mr.cyc));
      end
    end
    if (we || invtlb_valid) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe actual=we%0d/inv%0d required=none", we, invtlb_valid);
      end else begin
        ms = sq.pop_front();
        chk("strobe_kind", {87'd0, invtlb_valid, we}, {87'd0, ms.is_inv, ~ms.is_inv});
        chk("strobe_cycle", 89'(cyc), 89'(ms.cyc));
        if (ms.is_inv) begin
          chk("invtlb_op", 89'(invtlb_op), 89'(ms.op));
        end else begin
          chk("w_index", 89'(w_index), 89'(ms.index));
          chk("w_entry", w_entry, ms.entry);
        end
      end
    end
    if (!resetn) begin
      run = 0;
    end else if (!cmd_ready) begin
      run++;
    end else begin
      if (run != 0) chk("ready_low_cycles", 89'(run), 89'd2);
      run = 0;
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                      input logic [18:0] vppn, input logic [10:0] idx, input logic tlbr,
                      input logic [26:0] e0, input logic [26:0] e1, input bit hold,
                      input rsp_t er, input bit has_stb, input stb_t es);
    int n;
    int acc;
    cmd_op = op; cmd_inv_op = iop; cmd_asid = asid; cmd_vppn = vppn;
    csr_idx = idx; csr_tlbr = tlbr; csr_elo0 = e0; csr_elo1 = e1;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=high");
    end
    acc = cyc;
    er.cyc = acc + 2;
    rq.push_back(er);
    if (has_stb) begin
      es.cyc = acc + 1;
      sq.push_back(es);
    end
    @(negedge clk);
    cmd_valid = hold;
    cmd_op = 3'($urandom); cmd_inv_op = 5'($urandom); cmd_asid = 10'($urandom);
    cmd_vppn = 19'($urandom); csr_idx = 11'($urandom); csr_tlbr = 1'($urandom);
    csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
  endtask

  rsp_t r0;
  stb_t s0;
  logic [88:0] fill_ent;

  initial begin
    r0 = '{found: 1'b0, index: 4'd0, entry: 89'd0, err: 1'b0, cyc: 0};
    s0 = '{is_inv: 1'b0, index: 4'd0, entry: 89'd0, op: 5'd0, cyc: 0};
    @(negedge clk);
    chk("reset_cmd_ready", 89'(cmd_ready), 89'd1);
    chk("reset_we", 89'(we), 89'd0);
    chk("reset_invtlb_valid", 89'(invtlb_valid), 89'd0);
    chk("reset_rsp_valid", 89'(rsp_valid), 89'd0);
    chk("reset_rsp_fields", {rsp_found, rsp_err, rsp_index, 83'd0}, 89'd0);
    chk("reset_rsp_entry", rsp_entry, 89'd0);
    resetn = 1'b1;
    @(negedge clk);

    // SRCH hit and miss
    send(3'd0, 5'd0, 10'd5, 19'h12345, 11'd0, 1'b0, 27'd0, 27'd0, 1'b0,
         '{found: 1'b1, index: 4'd7, entry: 89'd0, err: 1'b0, cyc: 0}, 1'b0, s0);
    send(3'd0, 5'd0, 10'd5, 19'h00001, 11'd0, 1'b0, 27'd0, 27'd0, 1'b0, r0, 1'b0, s0);

    // Seventeen FILLs: pointer walks 0..15 then wraps to 0
    fill_ent = ent(1'b1, 19'h0ABCD, 6'd12, 10'h003, 1'b1, LO0, LO1);
    for (int i = 0; i < 17; i++) begin
      logic ne;
      ne = (i < 4) || (i % 2 == 0);
      send(3'd3, 5'd0, 10'h003, 19'h0ABCD, {ne, 6'd12, 4'd9}, ne, {LO0, 1'b1}, {LO1, 1'b1}, 1'b0,
           '{found: 1'b0, index: 4'(i % 16), entry: 89'd0, err: 1'b0, cyc: 0}, 1'b1,
           '{is_inv: 1'b0, index: 4'(i % 16), entry: fill_ent, op: 5'd0, cyc: 0});
    end

    // Back-to-back with cmd_valid held: WR, INV 5, INV 9, reserved ops, RD
    send(3'd2, 5'd0, 10'h2A5, 19'h51234, {1'b1, 6'd21, 4'd3}, 1'b0, {LO0, 1'b1}, {LO1, 1'b0}, 1'b1,
         r0, 1'b1,
         '{is_inv: 1'b0, index: 4'd3, entry: ent(1'b0, 19'h51234, 6'd21, 10'h2A5, 1'b0, LO0, LO1),
           op: 5'd0, cyc: 0});
    send(3'd4, 5'd5, 10'h01F, 19'h7FFFF, 11'd0, 1'b0, 27'd0, 27'd0, 1'b1, r0, 1'b1,
         '{is_inv: 1'b1, index: 4'd0, entry: 89'd0, op: 5'd5, cyc: 0});
    send(3'd4, 5'd9, 10'h01F, 19'h7FFFF, 11'd0, 1'b0, 27'd0, 27'd0, 1'b1,
         '{found: 1'b0, index: 4'd0, entry: 89'd0, err: 1'b1, cyc: 0}, 1'b0, s0);
    send(3'd6, 5'd0, 10'd0, 19'd0, 11'd0, 1'b0, 27'd0, 27'd0, 1'b1,
         '{found: 1'b0, index: 4'd0, entry: 89'd0, err: 1'b1, cyc: 0}, 1'b0, s0);
    send(3'd7, 5'd0, 10'd0, 19'd0, 11'd0, 1'b0, 27'd0, 27'd0, 1'b1,
         '{found: 1'b0, index: 4'd0, entry: 89'd0, err: 1'b1, cyc: 0}, 1'b0, s0);
    send(3'd1, 5'd0, 10'd0, 19'd0, {1'b0, 6'd0, 4'd2}, 1'b0, 27'd0, 27'd0, 1'b1, r0, 1'b0, s0);
    send(3'd1, 5'd0, 10'd0, 19'd0, {1'b0, 6'd0, 4'd9}, 1'b0, 27'd0, 27'd0, 1'b0,
         '{found: 1'b0, index: 4'd0, entry: ENT9, err: 1'b0, cyc: 0}, 1'b0, s0);
    repeat (4) @(negedge clk);

    // Reset pulse during EXEC of a WR: no strobe, no response, back to IDLE
    cmd_op = 3'd2; csr_idx = {1'b1, 6'd1, 4'd5}; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 89'(cmd_ready), 89'd1);
    chk("post_reset_rsp_entry", rsp_entry, 89'd0);
    chk("post_reset_we", 89'(we), 89'd0);

    // fill pointer restarts at 0 after reset
    send(3'd3, 5'd0, 10'h003, 19'h0ABCD, {1'b1, 6'd12, 4'd9}, 1'b1, {LO0, 1'b1}, {LO1, 1'b1}, 1'b0,
         r0, 1'b1, '{is_inv: 1'b0, index: 4'd0, entry: fill_ent, op: 5'd0, cyc: 0});
    repeat (5) @(negedge clk);
    chk("rsp_queue_drained", 89'(rq.size()), 89'd0);
    chk("strobe_queue_drained", 89'(sq.size()), 89'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
